// File: rtl/rbb_packer.sv
// rbb_packer
// Packs a stream of RES_WIDTH-bit results, slot by slot, into RBB_DATA_WIDTH-bit
// lines and writes them to consecutive result-batch-buffer addresses. A short
// batch (closed by res_last) is zero-padded up to the last buffer line. After
// the final line the buffer's task-done input is pulsed for one cycle, and new
// results are held off until the buffer reports it has drained.
//
// Ports:
//   clk, reset_n        core clock, synchronous active-low reset
//   res_valid/res_data/res_last/res_ready
//                       result stream in (accept = res_valid & res_ready)
//   rbb_wr_en/rbb_wr_addr/rbb_wr_din
//                       registered buffer write port
//   rbb_task_done       one-cycle pulse after the last line of a batch
//   rbb_full            buffer draining; new batch waits for it to drop
//   batch_count         completed (drained) batches, wraps modulo 2^16
module rbb_packer #(
    parameter int RBB_ADDR_WIDTH = 8,
    parameter int RBB_DATA_WIDTH = 512,
    parameter int RES_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      res_valid,
    input  logic [RES_WIDTH-1:0]      res_data,
    input  logic                      res_last,
    output logic                      res_ready,
    output logic                      rbb_wr_en,
    output logic [RBB_ADDR_WIDTH-1:0] rbb_wr_addr,
    output logic [RBB_DATA_WIDTH-1:0] rbb_wr_din,
    output logic                      rbb_task_done,
    input  logic                      rbb_full,
    output logic [15:0]               batch_count
);

    localparam int SLOTS  = RBB_DATA_WIDTH / RES_WIDTH;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [SLOT_W-1:0]         LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [RBB_ADDR_WIDTH-1:0] LAST_LINE = '1;

    localparam logic [2:0] FILL    = 3'd0;
    localparam logic [2:0] PAD     = 3'd1;
    localparam logic [2:0] LAST_WR = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [RBB_ADDR_WIDTH-1:0] line_idx_q, line_idx_d;
    logic [SLOT_W-1:0]         slot_idx_q, slot_idx_d;
    logic [RBB_DATA_WIDTH-1:0] line_q, line_d;
    logic                      wr_en_q, wr_en_d;
    logic [RBB_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [RBB_DATA_WIDTH-1:0] wr_din_q, wr_din_d;
    logic                      task_done_q, task_done_d;
    logic [15:0]               batch_count_q, batch_count_d;

    logic                      accept;
    logic [RBB_DATA_WIDTH-1:0] line_acc;

    // Gated by reset_n so the stream sees no ready while reset is asserted.
    assign res_ready = reset_n && (state_q == FILL) && !rbb_full;
    assign accept    = res_valid && res_ready;

    always_comb begin
        state_d       = state_q;
        line_idx_d    = line_idx_q;
        slot_idx_d    = slot_idx_q;
        line_d        = line_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_din_d      = wr_din_q;
        task_done_d   = 1'b0;
        batch_count_d = batch_count_q;

        // Current partial line with the incoming result merged in; the
        // accumulator is cleared on every close, so unfilled slots stay zero.
        line_acc = line_q;
        line_acc[int'(slot_idx_q) * RES_WIDTH +: RES_WIDTH] = res_data;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (slot_idx_q == LAST_SLOT || res_last) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = line_idx_q;
                        wr_din_d   = line_acc;
                        line_d     = '0;
                        slot_idx_d = '0;
                        if (line_idx_q == LAST_LINE) begin
                            // Buffer full: batch closes whether or not res_last was seen.
                            line_idx_d = '0;
                            state_d    = LAST_WR;
                        end else begin
                            line_idx_d = line_idx_q + RBB_ADDR_WIDTH'(1);
                            if (res_last) begin
                                state_d = PAD;
                            end
                        end
                    end else begin
                        line_d     = line_acc;
                        slot_idx_d = slot_idx_q + SLOT_W'(1);
                    end
                end
            end
            PAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = line_idx_q;
                wr_din_d  = '0;
                if (line_idx_q == LAST_LINE) begin
                    line_idx_d = '0;
                    state_d    = LAST_WR;
                end else begin
                    line_idx_d = line_idx_q + RBB_ADDR_WIDTH'(1);
                end
            end
            LAST_WR: begin
                // Final line is on the bus now; task_done follows next cycle.
                task_done_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!rbb_full) begin
                    state_d       = FILL;
                    line_idx_d    = '0;
                    slot_idx_d    = '0;
                    batch_count_d = batch_count_q + 16'd1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= FILL;
            line_idx_q    <= '0;
            slot_idx_q    <= '0;
            line_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_din_q      <= '0;
            task_done_q   <= 1'b0;
            batch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            line_idx_q    <= line_idx_d;
            slot_idx_q    <= slot_idx_d;
            line_q        <= line_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_din_q      <= wr_din_d;
            task_done_q   <= task_done_d;
            batch_count_q <= batch_count_d;
        end
    end

    assign rbb_wr_en     = wr_en_q;
    assign rbb_wr_addr   = wr_addr_q;
    assign rbb_wr_din    = wr_din_q;
    assign rbb_task_done = task_done_q;
    assign batch_count   = batch_count_q;

endmodule

// File: tb/tb_rbb_packer.sv
// Directed bench for rbb_packer with default parameters (256 lines x 16 slots).
// A negedge monitor records every buffer write and timing event; the main
// initial block drives batches and compares the recorded picture against
// hand-derived expectations. A small process stands in for the buffer's
// rbb_full behaviour after each task_done.
module tb_rbb_packer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         res_valid;
    logic [31:0]  res_data;
    logic         res_last;
    logic         res_ready;
    logic         rbb_wr_en;
    logic [7:0]   rbb_wr_addr;
    logic [511:0] rbb_wr_din;
    logic         rbb_task_done;
    logic         rbb_full;
    logic [15:0]  batch_count;

    always #5 clk = ~clk;

    rbb_packer #(
        .RBB_ADDR_WIDTH(8),
        .RBB_DATA_WIDTH(512),
        .RES_WIDTH     (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_last     (res_last),
        .res_ready    (res_ready),
        .rbb_wr_en    (rbb_wr_en),
        .rbb_wr_addr  (rbb_wr_addr),
        .rbb_wr_din   (rbb_wr_din),
        .rbb_task_done(rbb_task_done),
        .rbb_full     (rbb_full),
        .batch_count  (batch_count)
    );

    int checks = 0;
    int errors = 0;
    int drain_len = 5;
    logic clr_req = 1'b0;

    // Monitor state (written only by the monitor process).
    logic [511:0] mem [256];
    int   wcyc [256];
    int   cyc = 0;
    int   wr_cnt, td_cnt, last_wr_cyc, td_cyc, ord_bad, coinc, rdy_full, wr_full;
    int   fall_cyc, rise_cyc;
    logic [7:0] exp_addr;
    logic prev_full, prev_ready;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_full  <= rbb_full;
        prev_ready <= res_ready;
        if (clr_req) begin
            for (int k = 0; k < 256; k++) begin
                mem[k]  <= '1;
                wcyc[k] <= 0;
            end
            wr_cnt <= 0; td_cnt <= 0; last_wr_cyc <= 0; td_cyc <= 0;
            ord_bad <= 0; coinc <= 0; rdy_full <= 0; wr_full <= 0;
            fall_cyc <= 0; rise_cyc <= 0;
        end else begin
            if (!reset_n) exp_addr <= 8'd0;
            if (rbb_wr_en) begin
                if (rbb_wr_addr !== exp_addr) ord_bad <= ord_bad + 1;
                exp_addr          <= rbb_wr_addr + 8'd1;
                mem[rbb_wr_addr]  <= rbb_wr_din;
                wcyc[rbb_wr_addr] <= cyc;
                wr_cnt            <= wr_cnt + 1;
                if (rbb_wr_addr == 8'd255) last_wr_cyc <= cyc;
                if (rbb_full) wr_full <= wr_full + 1;
            end
            if (rbb_task_done) begin
                td_cnt <= td_cnt + 1;
                td_cyc <= cyc;
                if (rbb_wr_en) coinc <= coinc + 1;
            end
            if (rbb_full && res_ready) rdy_full <= rdy_full + 1;
            if (prev_full && !rbb_full) fall_cyc <= cyc;
            if (!prev_ready && res_ready) rise_cyc <= cyc;
        end
    end

    // Buffer stand-in: full from the cycle after task_done for drain_len cycles.
    initial begin
        rbb_full = 1'b0;
        forever begin
            @(negedge clk);
            if (rbb_task_done === 1'b1) begin
                @(posedge clk); #1;
                rbb_full = 1'b1;
                repeat (drain_len) @(posedge clk);
                #1;
                rbb_full = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        clr_req = 1'b1;
        @(negedge clk); #1;
        clr_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input int gap);
        logic r;
        int   n;
        repeat (gap) begin
            // Garbage on data/last while not valid must be ignored.
            res_valid = 1'b0; res_last = 1'b1; res_data = $urandom;
            @(posedge clk); #1;
        end
        res_valid = 1'b1; res_data = d; res_last = l;
        n = 0;
        do begin
            @(negedge clk);
            r = res_ready;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 20000);
        if (!r) chk("send_timeout", {63'd0, r}, 64'd1);
        res_valid = 1'b0; res_last = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_ready && n < 20000);
        chk(tag, {63'd0, res_ready}, 64'd1);
        @(posedge clk); #1;
    endtask

    int bad;

    initial begin
        reset_n = 1'b0; res_valid = 1'b0; res_data = '0; res_last = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   {63'd0, rbb_wr_en}, 64'd0);
        chk("rst_wr_addr", {56'd0, rbb_wr_addr}, 64'd0);
        chk("rst_wr_din",  {63'd0, |rbb_wr_din}, 64'd0);
        chk("rst_td",      {63'd0, rbb_task_done}, 64'd0);
        chk("rst_bcnt",    {48'd0, batch_count}, 64'd0);
        chk("rst_ready",   {63'd0, res_ready}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {63'd0, res_ready}, 64'd1);
        clr();

        // Full batch: 4096 results, no res_last
        for (int i = 0; i < 4096; i++) send(i, 1'b0, 0);
        wait_ready("full_ready_back");
        bad = 0;
        for (int k = 0; k < 256; k++)
            for (int j = 0; j < 16; j++)
                if (mem[k][j*32 +: 32] !== 32'(16*k + j)) bad++;
        chk("full_data_bad", bad, 0);
        chk("full_l255_s15", {32'd0, mem[255][511:480]}, 64'd4095);
        chk("full_wr_cnt", wr_cnt, 256);
        chk("full_order", ord_bad, 0);
        chk("full_td_cnt", td_cnt, 1);
        chk("full_td_delay", td_cyc - last_wr_cyc, 1);
        chk("full_td_coinc", coinc, 0);
        chk("full_rdy_full", rdy_full, 0);
        chk("full_ready_rise", rise_cyc - fall_cyc, 1);
        chk("full_bcnt", {48'd0, batch_count}, 64'd1);

        // Short batch with random bubbles, long drain
        drain_len = 300;
        clr();
        for (int i = 0; i < 20; i++) send(1000 + i, (i == 19), $urandom_range(0, 3));
        wait_ready("short_ready_back");
        bad = 0;
        for (int j = 0; j < 16; j++) if (mem[0][j*32 +: 32] !== 32'(1000 + j)) bad++;
        for (int j = 0; j < 4; j++)  if (mem[1][j*32 +: 32] !== 32'(1016 + j)) bad++;
        for (int j = 4; j < 16; j++) if (mem[1][j*32 +: 32] !== 32'd0) bad++;
        chk("short_data_bad", bad, 0);
        bad = 0;
        for (int k = 2; k < 256; k++) if (mem[k] !== '0) bad++;
        chk("short_pad_zero", bad, 0);
        chk("short_pad_span", wcyc[255] - wcyc[2], 253);
        chk("short_wr_cnt", wr_cnt, 256);
        chk("short_order", ord_bad, 0);
        chk("short_td_delay", td_cyc - last_wr_cyc, 1);
        chk("short_wr_full", wr_full, 0);
        chk("short_rdy_full", rdy_full, 0);
        chk("short_ready_rise", rise_cyc - fall_cyc, 1);
        chk("short_bcnt", {48'd0, batch_count}, 64'd2);

        // Last on line boundary
        drain_len = 5;
        clr();
        for (int i = 0; i < 16; i++) send(200 + i, (i == 15), 0);
        wait_ready("bnd_ready_back");
        bad = 0;
        for (int j = 0; j < 16; j++) if (mem[0][j*32 +: 32] !== 32'(200 + j)) bad++;
        for (int k = 1; k < 256; k++) if (mem[k] !== '0) bad++;
        chk("bnd_data_bad", bad, 0);
        chk("bnd_wr_cnt", wr_cnt, 256);
        chk("bnd_order", ord_bad, 0);
        chk("bnd_bcnt", {48'd0, batch_count}, 64'd3);

        // Reset during the line-100 pad write
        clr();
        for (int i = 0; i < 5; i++) send(i + 1, (i == 4), 0);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(rbb_wr_en && rbb_wr_addr == 8'd100) && n < 1000);
        end
        chk("pad100_seen", {56'd0, rbb_wr_addr}, 64'd100);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_wr_en",   {63'd0, rbb_wr_en}, 64'd0);
        chk("mid_wr_addr", {56'd0, rbb_wr_addr}, 64'd0);
        chk("mid_wr_din",  {63'd0, |rbb_wr_din}, 64'd0);
        chk("mid_td",      {63'd0, rbb_task_done}, 64'd0);
        chk("mid_bcnt",    {48'd0, batch_count}, 64'd0);
        chk("mid_ready",   {63'd0, res_ready}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        clr();
        repeat (300) @(posedge clk);
        #1;
        chk("mid_no_td", td_cnt, 0);
        chk("mid_no_wr", wr_cnt, 0);
        send(32'd7, 1'b0, 0);
        send(32'd8, 1'b0, 0);
        send(32'd9, 1'b1, 0);
        wait_ready("post_rst_ready_back");
        chk("post_line0_lo", mem[0][63:0], {32'd8, 32'd7});
        chk("post_line0_s2", mem[0][127:64], {32'd0, 32'd9});
        chk("post_line0_hi", {63'd0, |mem[0][511:128]}, 64'd0);
        chk("post_wr_cnt", wr_cnt, 256);
        chk("post_order", ord_bad, 0);
        chk("post_bcnt", {48'd0, batch_count}, 64'd1);

        // Back-to-back: 4100 results without res_last, then 12 more to close line 0 of batch 2
        clr();
        for (int i = 0; i < 4112; i++) send(5000 + i, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        bad = 0;
        for (int k = 1; k < 256; k++)
            for (int j = 0; j < 16; j++)
                if (mem[k][j*32 +: 32] !== 32'(5000 + 16*k + j)) bad++;
        for (int j = 0; j < 16; j++) if (mem[0][j*32 +: 32] !== 32'(5000 + 4096 + j)) bad++;
        chk("b2b_data_bad", bad, 0);
        chk("b2b_l1_s0", {32'd0, mem[1][31:0]}, 64'd5016);
        chk("b2b_wr_cnt", wr_cnt, 257);
        chk("b2b_order", ord_bad, 0);
        chk("b2b_td_cnt", td_cnt, 1);
        chk("b2b_bcnt", {48'd0, batch_count}, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
